// File: rtl/arbitro_memoria.sv
// -----------------------------------------------------------------------------
// arbitro_memoria
//
// Two-requester arbiter for a single-port data memory. Requester 0 is the CPU
// and requester 1 is the I/O side. Each access takes three states:
// OCIOSO (idle, sample requests) -> ACESSO (memory strobe) -> CONCLUI (Ack).
//
// Configuration macro:
//   ARBITRO_RODIZIO_EN  defined   : round-robin between requesters, using a
//                                   last-served pointer (reset value 1).
//                       undefined : fixed priority, requester 0 always wins,
//                                   no pointer register.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   Req0/Req1           access requests (0 = CPU, 1 = I/O)
//   Esc0/Esc1           1 = write, 0 = read
//   End0/End1           requested addresses
//   Dado0/Dado1         write data
//   Ack0/Ack1           one-cycle completion pulse (CONCLUI)
//   Lido0/Lido1         last read data returned to each requester
//   Endereco            memory address (latched address of the winner)
//   DadoEscrito         memory write data (latched data of the winner)
//   EscMem/LerMem       registered write/read strobes, high only in ACESSO
//   DadoLido            memory read data, valid after the falling-edge read
//   Ocupado             high while the FSM is not in OCIOSO
// -----------------------------------------------------------------------------
module arbitro_memoria #(
    parameter int LARGURA_END  = 8,
    parameter int LARGURA_DADO = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    Req0,
    input  logic                    Req1,
    input  logic                    Esc0,
    input  logic                    Esc1,
    input  logic [LARGURA_END-1:0]  End0,
    input  logic [LARGURA_END-1:0]  End1,
    input  logic [LARGURA_DADO-1:0] Dado0,
    input  logic [LARGURA_DADO-1:0] Dado1,
    output logic                    Ack0,
    output logic                    Ack1,
    output logic [LARGURA_DADO-1:0] Lido0,
    output logic [LARGURA_DADO-1:0] Lido1,
    output logic [LARGURA_END-1:0]  Endereco,
    output logic [LARGURA_DADO-1:0] DadoEscrito,
    output logic                    EscMem,
    output logic                    LerMem,
    input  logic [LARGURA_DADO-1:0] DadoLido,
    output logic                    Ocupado
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        ACESSO  = 2'b01,
        CONCLUI = 2'b10
    } estado_t;

    estado_t                 state_r;
    estado_t                 next_state_s;

    // Winner of the current access (0 = CPU, 1 = I/O) and its latched request
    logic                    venc_r;
    logic                    venc_s;
    logic                    esc_r;
    logic                    esc_s;
    logic [LARGURA_END-1:0]  end_r;
    logic [LARGURA_END-1:0]  end_s;
    logic [LARGURA_DADO-1:0] dado_r;
    logic [LARGURA_DADO-1:0] dado_s;

    logic                    esc_mem_r;
    logic                    esc_mem_s;
    logic                    ler_mem_r;
    logic                    ler_mem_s;
    logic                    ack0_r;
    logic                    ack0_s;
    logic                    ack1_r;
    logic                    ack1_s;
    logic [LARGURA_DADO-1:0] lido0_r;
    logic [LARGURA_DADO-1:0] lido0_s;
    logic [LARGURA_DADO-1:0] lido1_r;
    logic [LARGURA_DADO-1:0] lido1_s;
    logic                    ocupado_r;

    // Requester that would win if the FSM samples requests this cycle
    logic                    sel_s;
    logic                    req_any_s;

    assign req_any_s = Req0 | Req1;

`ifdef ARBITRO_RODIZIO_EN
    logic                    ultimo_r;

    // Round-robin grant: on a conflict, serve whoever was not served last
    always_comb begin
        sel_s = 1'b0;
        if (Req0 && Req1) begin
            sel_s = ~ultimo_r;
        end else begin
            sel_s = ~Req0;
        end
    end

    // Last-served pointer, advanced on every OCIOSO->ACESSO edge
    always_ff @(posedge clock) begin
        if (reset) begin
            ultimo_r <= 1'b1;
        end else if ((state_r == OCIOSO) && req_any_s) begin
            ultimo_r <= sel_s;
        end else begin
            ultimo_r <= ultimo_r;
        end
    end
`else
    // Fixed-priority grant: the CPU always wins a conflict
    always_comb begin
        sel_s = 1'b0;
        if (Req0) begin
            sel_s = 1'b0;
        end else begin
            sel_s = 1'b1;
        end
    end
`endif

    // Next-state logic: one access always walks the full three-state cycle
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            OCIOSO: begin
                if (req_any_s) begin
                    next_state_s = ACESSO;
                end else begin
                    next_state_s = OCIOSO;
                end
            end
            ACESSO:  next_state_s = CONCLUI;
            CONCLUI: next_state_s = OCIOSO;
            default: next_state_s = OCIOSO;
        endcase
    end

    // Next values of the latched request and of all registered outputs
    always_comb begin
        venc_s    = venc_r;
        esc_s     = esc_r;
        end_s     = end_r;
        dado_s    = dado_r;
        esc_mem_s = 1'b0;
        ler_mem_s = 1'b0;
        ack0_s    = 1'b0;
        ack1_s    = 1'b0;
        lido0_s   = lido0_r;
        lido1_s   = lido1_r;
        case (state_r)
            OCIOSO: begin
                if (req_any_s) begin
                    venc_s = sel_s;
                    if (sel_s) begin
                        esc_s  = Esc1;
                        end_s  = End1;
                        dado_s = Dado1;
                    end else begin
                        esc_s  = Esc0;
                        end_s  = End0;
                        dado_s = Dado0;
                    end
                    // Strobes are set here so they are valid for the whole ACESSO cycle
                    esc_mem_s = esc_s;
                    ler_mem_s = ~esc_s;
                end else begin
                    esc_mem_s = 1'b0;
                    ler_mem_s = 1'b0;
                end
            end
            ACESSO: begin
                if (venc_r) begin
                    ack1_s = 1'b1;
                end else begin
                    ack0_s = 1'b1;
                end
                // The memory's falling-edge read has settled DadoLido by now
                if (!esc_r) begin
                    if (venc_r) begin
                        lido1_s = DadoLido;
                    end else begin
                        lido0_s = DadoLido;
                    end
                end else begin
                    lido0_s = lido0_r;
                    lido1_s = lido1_r;
                end
            end
            CONCLUI: begin
                ack0_s = 1'b0;
                ack1_s = 1'b0;
            end
            default: begin
                ack0_s = 1'b0;
                ack1_s = 1'b0;
            end
        endcase
    end

    // State, latched request and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= OCIOSO;
            venc_r    <= 1'b0;
            esc_r     <= 1'b0;
            end_r     <= {LARGURA_END{1'b0}};
            dado_r    <= {LARGURA_DADO{1'b0}};
            esc_mem_r <= 1'b0;
            ler_mem_r <= 1'b0;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            lido0_r   <= {LARGURA_DADO{1'b0}};
            lido1_r   <= {LARGURA_DADO{1'b0}};
            ocupado_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            venc_r    <= venc_s;
            esc_r     <= esc_s;
            end_r     <= end_s;
            dado_r    <= dado_s;
            esc_mem_r <= esc_mem_s;
            ler_mem_r <= ler_mem_s;
            ack0_r    <= ack0_s;
            ack1_r    <= ack1_s;
            lido0_r   <= lido0_s;
            lido1_r   <= lido1_s;
            ocupado_r <= (next_state_s != OCIOSO);
        end
    end

    assign Endereco    = end_r;
    assign DadoEscrito = dado_r;
    assign EscMem      = esc_mem_r;
    assign LerMem      = ler_mem_r;
    assign Ack0        = ack0_r;
    assign Ack1        = ack1_r;
    assign Lido0       = lido0_r;
    assign Lido1       = lido1_r;
    assign Ocupado     = ocupado_r;

endmodule
